// File: rtl/pause_dim_pkg.sv
// Shared types and constants for the pause/dim controller.
package pause_dim_pkg;

    // Dimming controller states
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DIM  = 2'd2
    } state_t;

    // Full brightness, expressed in eighths
    localparam logic [3:0]  LEVEL_FULL        = 4'd8;

    // Ten seconds of continuous pause at 48 MHz
    localparam logic [31:0] DIM_TICKS_DEFAULT = 32'h1C9C3800;

    // Move a brightness level one step toward a target, holding once it is reached
    function automatic logic [3:0] step_toward(input logic [3:0] cur, input logic [3:0] tgt);
        if (cur > tgt) begin
            return cur - 4'd1;
        end else if (cur < tgt) begin
            return cur + 4'd1;
        end else begin
            return cur;
        end
    endfunction

endpackage

// File: rtl/pause_dim_ctrl_pix_scale.sv
// One colour channel scaled by a brightness level in eighths.
// The 4x4 product is kept to 8 bits and shifted down by 3, so level 8
// gives back the input unchanged.
module pix_scale (
    input  logic [3:0] i_chan,
    input  logic [3:0] i_level,
    output logic [3:0] o_chan
);

    logic [7:0] w_prod;

    assign w_prod = i_chan * i_level;
    assign o_chan = 4'(w_prod >> 3);

endmodule

// File: rtl/pause_dim_ctrl.sv
// Pause request generation plus screen dimming after a long pause.
// The pause button toggles a latch; any pause source holding for DIM_TICKS
// cycles starts a fade to MIN_LEVEL, one step per vertical blank.
// Video passes through a one-ce_pix register stage that applies the level.
module pause_dim_ctrl
    import pause_dim_pkg::*;
#(
    parameter logic [31:0] DIM_TICKS = DIM_TICKS_DEFAULT,
    parameter int unsigned MIN_LEVEL = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce_pix,
    input  logic        pause_btn,
    input  logic        hs_access,
    input  logic        osd_status,
    input  logic        osd_pause_en,
    input  logic [11:0] rgb_in,
    input  logic        hblank_in,
    input  logic        vblank_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic        pause,
    output logic [3:0]  level,
    output logic [11:0] rgb_out,
    output logic        hblank_out,
    output logic        vblank_out,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam logic [3:0] LP_MIN_LEVEL = 4'(MIN_LEVEL);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_btn_prev;
    logic        r_toggle;
    logic [31:0] r_timer;
    logic [3:0]  r_level;
    logic [11:0] r_rgb;
    logic        r_hblank;
    logic        r_vblank;
    logic        r_hsync;
    logic        r_vsync;

    logic        w_pause;
    logic [3:0]  w_target;
    logic        w_vb_rise;
    logic [11:0] w_scaled;

    // Any of the three sources pauses the core; the button only through its latch
    assign w_pause = hs_access | r_toggle | (osd_status & osd_pause_en);

    // Button rising edge flips the pause latch
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_prev <= 1'b0;
            r_toggle   <= 1'b0;
        end else begin
            r_btn_prev <= pause_btn;
            if (pause_btn && !r_btn_prev) begin
                r_toggle <= ~r_toggle;
            end
        end
    end

    // Controller state register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: any drop of pause returns to RUN
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_pause) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!w_pause) begin
                    w_state_next = ST_RUN;
                end else if (r_timer == DIM_TICKS) begin
                    w_state_next = ST_DIM;
                end
            end
            ST_DIM: begin
                if (!w_pause) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // Pause-duration timer, saturating so it cannot wrap during very long pauses
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= 32'd0;
        end else if (!w_pause || (r_state == ST_RUN)) begin
            r_timer <= 32'd0;
        end else if ((r_state == ST_WAIT) && (r_timer < DIM_TICKS)) begin
            r_timer <= r_timer + 32'd1;
        end
    end

    // The registered vblank output doubles as the previous vblank sample
    assign w_target  = (r_state == ST_DIM) ? LP_MIN_LEVEL : LEVEL_FULL;
    assign w_vb_rise = vblank_in & ~r_vblank;

    // Brightness walks one step per frame toward its target, in either direction
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_level <= LEVEL_FULL;
        end else if (ce_pix && w_vb_rise) begin
            r_level <= step_toward(r_level, w_target);
        end
    end

    // One multiplier per colour channel
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            pix_scale u_pix_scale (
                .i_chan  (rgb_in[gi*4 +: 4]),
                .i_level (r_level),
                .o_chan  (w_scaled[gi*4 +: 4])
            );
        end
    endgenerate

    // Video output stage: pixel and timing advance together on each ce_pix
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb    <= 12'h000;
            r_hblank <= 1'b1;
            r_vblank <= 1'b1;
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
        end else if (ce_pix) begin
            r_rgb    <= (hblank_in || vblank_in) ? 12'h000 : w_scaled;
            r_hblank <= hblank_in;
            r_vblank <= vblank_in;
            r_hsync  <= hsync_in;
            r_vsync  <= vsync_in;
        end
    end

    assign pause      = w_pause;
    assign level      = r_level;
    assign rgb_out    = r_rgb;
    assign hblank_out = r_hblank;
    assign vblank_out = r_vblank;
    assign hsync_out  = r_hsync;
    assign vsync_out  = r_vsync;

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// Randomized bench for pause_dim_ctrl against a frame-level behavioural model.
// The model tracks how long pause has been held continuously and derives the
// dim decision from that run length, rather than from controller states.
module tb_pause_dim_ctrl;

    localparam int D    = 100;
    localparam int MINL = 4;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b1;
    logic        ce_pix = 1'b0;
    logic        pause_btn = 1'b0;
    logic        hs_access = 1'b0;
    logic        osd_status = 1'b0;
    logic        osd_pause_en = 1'b0;
    logic [11:0] rgb_in = 12'h000;
    logic        hblank_in = 1'b0;
    logic        vblank_in = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        pause;
    logic [3:0]  level;
    logic [11:0] rgb_out;
    logic        hblank_out;
    logic        vblank_out;
    logic        hsync_out;
    logic        vsync_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_toggle;
    bit          m_btn_prev;
    int          m_run;
    int          m_level;
    bit          m_vb_prev;
    logic [11:0] m_rgb;
    logic [3:0]  m_tim;

    always #5 clk_sys = ~clk_sys;

    pause_dim_ctrl #(
        .DIM_TICKS (32'd100),
        .MIN_LEVEL (4)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ce_pix       (ce_pix),
        .pause_btn    (pause_btn),
        .hs_access    (hs_access),
        .osd_status   (osd_status),
        .osd_pause_en (osd_pause_en),
        .rgb_in       (rgb_in),
        .hblank_in    (hblank_in),
        .vblank_in    (vblank_in),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .pause        (pause),
        .level        (level),
        .rgb_out      (rgb_out),
        .hblank_out   (hblank_out),
        .vblank_out   (vblank_out),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_pause();
        return hs_access | m_toggle | (osd_status & osd_pause_en);
    endfunction

    task automatic model_reset();
        m_toggle   = 1'b0;
        m_btn_prev = 1'b0;
        m_run      = 0;
        m_level    = 8;
        m_vb_prev  = 1'b1;
        m_rgb      = 12'h000;
        m_tim      = 4'hF;
    endtask

    // One clock edge of intended behaviour
    task automatic model_clock();
        bit          p;
        int          tgt;
        int          ch;
        logic [11:0] o;
        p   = model_pause();
        // Dimmed once pause has held long enough for the timer to reach DIM_TICKS and be seen
        tgt = (m_run >= D + 2) ? MINL : 8;
        if (ce_pix) begin
            o = 12'h000;
            for (int c = 0; c < 3; c++) begin
                ch = int'((rgb_in >> (4 * c)) & 12'hF);
                o  = o | 12'(((ch * m_level) / 8) << (4 * c));
            end
            if (hblank_in || vblank_in) o = 12'h000;
            m_rgb = o;
            m_tim = {hblank_in, vblank_in, hsync_in, vsync_in};
            if (vblank_in && !m_vb_prev) begin
                if (m_level > tgt) m_level = m_level - 1;
                else if (m_level < tgt) m_level = m_level + 1;
            end
            m_vb_prev = vblank_in;
        end
        m_run = p ? ((m_run < 1000000) ? m_run + 1 : m_run) : 0;
        if (pause_btn && !m_btn_prev) m_toggle = ~m_toggle;
        m_btn_prev = pause_btn;
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge
    task automatic step();
        #1;
        check_val("pause", {31'd0, pause}, {31'd0, model_pause()});
        @(posedge clk_sys);
        model_clock();
        #1;
        check_val("level", {28'd0, level}, 32'(m_level));
        check_val("rgb_out", {20'd0, rgb_out}, {20'd0, m_rgb});
        check_val("timing", {28'd0, hblank_out, vblank_out, hsync_out, vsync_out}, {28'd0, m_tim});
        @(negedge clk_sys);
    endtask

    task automatic idle_video();
        ce_pix    = 1'($urandom_range(0, 1));
        rgb_in    = 12'($urandom);
        hblank_in = 1'($urandom_range(0, 1));
        vblank_in = 1'b0;
        hsync_in  = 1'($urandom_range(0, 1));
        vsync_in  = 1'($urandom_range(0, 1));
    endtask

    task automatic rand_video();
        ce_pix    = 1'($urandom_range(0, 1));
        rgb_in    = 12'($urandom);
        hblank_in = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 5) == 0) vblank_in = ~vblank_in;
        hsync_in  = 1'($urandom_range(0, 1));
        vsync_in  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            idle_video();
            step();
        end
    endtask

    task automatic press();
        idle_video();
        pause_btn = 1'b1;
        step();
        idle_video();
        pause_btn = 1'b0;
        step();
    endtask

    // One vblank rising edge seen on ce_pix, then check the level it produced
    task automatic vb_edge(input string tag, input int exp_level);
        idle_video();
        ce_pix = 1'b1;
        vblank_in = 1'b0;
        step();
        idle_video();
        ce_pix = 1'b1;
        vblank_in = 1'b1;
        step();
        check_val(tag, {28'd0, level}, 32'(exp_level));
        idle_video();
        ce_pix = 1'b0;
        vblank_in = 1'b1;
        step();
        $display("vblank edge %s: level %0d", tag, level);
    endtask

    task automatic white_pixel(input string tag, input logic [11:0] exp);
        idle_video();
        ce_pix    = 1'b1;
        rgb_in    = 12'hFFF;
        hblank_in = 1'b0;
        vblank_in = 1'b0;
        step();
        check_val(tag, {20'd0, rgb_out}, {20'd0, exp});
        $display("pixel %s: rgb_out %03h", tag, rgb_out);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rst_level", {28'd0, level}, 32'd8);
        check_val("rst_rgb", {20'd0, rgb_out}, 32'd0);
        check_val("rst_timing", {28'd0, hblank_out, vblank_out, hsync_out, vsync_out}, 32'hF);
        check_val("rst_pause", {31'd0, pause}, 32'd0);
        $display("reset: level %0d rgb %03h", level, rgb_out);
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        model_reset();

        // Fade down to the floor, then back up after release
        press();
        wait_cycles(D + 10);
        vb_edge("dim_7", 7);
        vb_edge("dim_6", 6);
        vb_edge("dim_5", 5);
        vb_edge("dim_4", 4);
        vb_edge("dim_hold", 4);
        white_pixel("rgb_l4", 12'h777);
        press();
        vb_edge("up_5", 5);
        vb_edge("up_6", 6);
        vb_edge("up_7", 7);
        vb_edge("up_8", 8);
        white_pixel("rgb_l8", 12'hFFF);
        idle_video();
        ce_pix = 1'b0;
        rgb_in = 12'h000;
        step();
        check_val("rgb_hold", {20'd0, rgb_out}, 32'hFFF);

        // Release mid fade reverses without a jump
        press();
        wait_cycles(D + 10);
        vb_edge("mid_7", 7);
        vb_edge("mid_6", 6);
        press();
        check_val("release_pause", {31'd0, pause}, 32'd0);
        vb_edge("rev_7", 7);
        vb_edge("rev_8", 8);

        // Hiscore access pauses only while present and never dims
        hs_access = 1'b1;
        for (int i = 0; i < 50; i++) begin
            rand_video();
            #1;
            check_val("hs_pause", {31'd0, pause}, 32'd1);
            step();
        end
        hs_access = 1'b0;
        idle_video();
        #1;
        check_val("hs_off", {31'd0, pause}, 32'd0);
        check_val("hs_level", {28'd0, level}, 32'd8);
        step();
        $display("hiscore window: level %0d", level);

        // OSD pause needs the option enabled, and responds in the same cycle
        osd_status = 1'b1;
        osd_pause_en = 1'b0;
        #1;
        check_val("osd_noen", {31'd0, pause}, 32'd0);
        osd_pause_en = 1'b1;
        #1;
        check_val("osd_en", {31'd0, pause}, 32'd1);
        step();
        osd_status = 1'b0;
        osd_pause_en = 1'b0;
        idle_video();
        step();
        $display("osd: pause %0d", pause);

        // Button edge during hiscore access still toggles
        hs_access = 1'b1;
        idle_video();
        pause_btn = 1'b1;
        step();
        pause_btn = 1'b0;
        idle_video();
        step();
        hs_access = 1'b0;
        #1;
        check_val("coinc_toggle", {31'd0, pause}, 32'd1);
        step();
        press();
        check_val("coinc_release", {31'd0, pause}, 32'd0);
        $display("coincident toggle: pause %0d", pause);

        // Asynchronous reset mid fade restores full level at once
        press();
        wait_cycles(D + 10);
        vb_edge("pre_rst_7", 7);
        vb_edge("pre_rst_6", 6);
        vb_edge("pre_rst_5", 5);
        white_pixel("rgb_l5", 12'h999);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("arst_level", {28'd0, level}, 32'd8);
        check_val("arst_rgb", {20'd0, rgb_out}, 32'd0);
        check_val("arst_timing", {28'd0, hblank_out, vblank_out, hsync_out, vsync_out}, 32'hF);
        check_val("arst_pause", {31'd0, pause}, 32'd0);
        $display("async reset: level %0d rgb %03h", level, rgb_out);
        @(negedge clk_sys);
        reset_n = 1'b1;
        model_reset();
        vb_edge("post_rst_a", 8);
        vb_edge("post_rst_b", 8);

        // Random soak across all pause sources
        for (int i = 0; i < 2500; i++) begin
            rand_video();
            if ($urandom_range(0, 149) == 0) pause_btn = ~pause_btn;
            if ($urandom_range(0, 299) == 0) hs_access = ~hs_access;
            if ($urandom_range(0, 199) == 0) osd_status = ~osd_status;
            if ($urandom_range(0, 199) == 0) osd_pause_en = ~osd_pause_en;
            step();
        end
        $display("soak done: level %0d", level);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pause_dim_ctrl.md
PAUSE_DIM_CTRL -- requirements
Module: pause_dim_ctrl

Interface
REQ-001 SHALL have parameter DIM_TICKS, default 32'h1C9C3800, clk_sys cycles of continuous pause before dimming starts (10 s @ 48 MHz).
REQ-002 SHALL have parameter MIN_LEVEL, default 4, dimmed brightness level in eighths (valid 0..8).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk_sys  in  1  system clock (48 MHz); all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 ce_pix  in  1  pixel clock enable, one-cycle pulse.
REQ-007 pause_btn  in  1  user pause button level, synchronous to clk_sys.
REQ-008 hs_access  in  1  hiscore engine RAM access request.
REQ-009 osd_status  in  1  OSD open.
REQ-010 osd_pause_en  in  1  pause-on-OSD option enabled.
REQ-011 rgb_in  in  12  {b,g,r} 4 bits each, from the video timing stage.
REQ-012 hblank_in, vblank_in, hsync_in, vsync_in  in  1 each  timing from the video timing stage (sync active-low).
REQ-013 pause  out  1  core pause request.
REQ-014 level  out  4  current brightness level, 0..8.
REQ-015 rgb_out  out  12  scaled pixel.
REQ-016 hblank_out, vblank_out, hsync_out, vsync_out  out  1 each  timing delayed to match rgb_out.

Function
REQ-017 toggle SHALL invert on each pause_btn rising edge (previous-cycle register compare), independent of the other pause sources.
REQ-018 pause SHALL equal hs_access | toggle | (osd_status & osd_pause_en), combinational from registered toggle.
REQ-019 FSM states: RUN, WAIT, DIM.
REQ-020 RUN->WAIT when pause=1; WAIT->RUN when pause=0; WAIT->DIM when timer==DIM_TICKS; DIM->RUN when pause=0.
REQ-021 32-bit timer SHALL increment each cycle in WAIT, saturate at DIM_TICKS, and clear to 0 in RUN and whenever pause=0.
REQ-022 target level SHALL be MIN_LEVEL in DIM, else 8.
REQ-023 level SHALL step by exactly 1 toward target on each vblank_in rising edge sampled on ce_pix; hold when equal.
REQ-024 pause deasserting mid fade-down SHALL reverse direction from the current level, with no jump.
REQ-025 On ce_pix, each channel out SHALL be (chan*level)>>3, 8-bit product truncated; level 8 SHALL be exact passthrough.
REQ-026 rgb_out SHALL be forced to 0 when hblank_in|vblank_in at sample time.
REQ-027 Latency SHALL be exactly one ce_pix from input sample to all outputs; outputs SHALL hold between ce_pix pulses.
REQ-028 A pause_btn edge coincident with hs_access SHALL still toggle; pause stays 1.

Reset
REQ-029 On reset_n=0: state RUN, toggle 0, timer 0, level 8, rgb_out 0, hblank_out 1, vblank_out 1, hsync_out 1, vsync_out 1, edge register 0.
REQ-030 Reset asserted mid-fade SHALL restore level 8 immediately; no fade-up after release.

Structure
REQ-031 Package pause_dim_pkg SHALL hold the state enum, LEVEL_FULL=8, and the DIM_TICKS default.
REQ-032 One sub-module, pix_scale, SHALL implement the per-channel 4x4 multiply-shift; it SHALL be instantiated three times.

Verification
REQ-033 DIM_TICKS=100. Pulse pause_btn, then wait 101 cycles -> state DIM; level 8->7->6->5->4 over 4 vblank edges, then holds at 4.
REQ-034 rgb_in=12'hFFF, level 4 -> rgb_out=12'h777; level 8 -> rgb_out=12'hFFF one ce_pix later.
REQ-035 Release pause at level 6 -> next vblank edges give 7, then 8; timer reads 0.
REQ-036 hs_access high for 50 cycles, no button -> pause=1 for exactly those cycles, state never DIM, level stays 8.
REQ-037 Assert reset_n=0 at level 5 -> level 8, rgb_out 0, all blanks 1, with no clock edge required.
REQ-038 osd_status=1 with osd_pause_en=0 -> pause=0; set osd_pause_en=1 -> pause=1 the same cycle.
